// File: rtl/cmd_pkg.sv
// Shared command-format definitions for the CPU command path: header field
// positions, opcodes and parser state encodings.
package cmd_pkg;

   // Header field positions (32-bit command word)
   localparam int TOCPU_BIT = 31;
   localparam int OP_MSB    = 30;
   localparam int OP_LSB    = 28;
   localparam int LEN_MSB   = 27;
   localparam int LEN_LSB   = 20;
   localparam int RCNT_MSB  = 19;
   localparam int RCNT_LSB  = 16;
   localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;

   // Opcodes
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_READ  = 3'd2;

   // Parser states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_SKIP  = 2'd2
   } parse_state_t;

endpackage

// File: rtl/cpu_cmd_decoder_if.sv
// Bus bundle between the command decoder and its neighbours: the CPU word
// stream in, register writes and read requests out, plus status.
interface cpu_cmd_decoder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] cmd_data_i;
   logic                  cmd_we_i;
   logic                  reg_we_o;
   logic [ADDR_WIDTH-1:0] reg_addr_o;
   logic [DATA_WIDTH-1:0] reg_data_o;
   logic                  rd_req_o;
   logic [ADDR_WIDTH-1:0] rd_addr_o;
   logic                  rd_ready_i;
   logic                  busy_o;
   logic                  err_o;
   logic                  err_clr_i;
   logic [15:0]           cmd_cnt_o;

   // Decoder side
   modport slave (
      input  cmd_data_i, cmd_we_i, rd_ready_i, err_clr_i,
      output reg_we_o, reg_addr_o, reg_data_o, rd_req_o, rd_addr_o,
             busy_o, err_o, cmd_cnt_o
   );

   // Driver / environment side
   modport master (
      output cmd_data_i, cmd_we_i, rd_ready_i, err_clr_i,
      input  reg_we_o, reg_addr_o, reg_data_o, rd_req_o, rd_addr_o,
             busy_o, err_o, cmd_cnt_o
   );
endinterface

// File: rtl/cmd_rd_issuer.sv
// Read burst engine: loaded with a start address and count, presents one
// request at a time and advances on each ready/valid handshake.
module cmd_rd_issuer #(
   parameter int ADDR_WIDTH   = 8,
   parameter int RD_CNT_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  reset,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [RD_CNT_WIDTH:0] load_cnt,
   input  logic                  ready,
   output logic                  req,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  active
);
   localparam int RC_W = RD_CNT_WIDTH + 1;

   logic                  req_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [RC_W-1:0]       cnt_q;

   // Load a burst, then step address/count on every accepted request
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         req_q  <= 1'b0;
         addr_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         req_q  <= 1'b1;
         addr_q <= load_addr;
         cnt_q  <= load_cnt;
      end else if (req_q && ready) begin
         addr_q <= addr_q + ADDR_WIDTH'(1);
         cnt_q  <= cnt_q - RC_W'(1);
         if (cnt_q == RC_W'(1)) begin
            req_q <= 1'b0;
         end
      end
   end

   assign req    = req_q;
   assign addr   = addr_q;
   assign active = req_q;

endmodule

// File: rtl/cpu_cmd_decoder.sv
// Command packet parser for the CPU word stream: decodes headers, turns WRITE
// payloads into register write strobes, skips NOP/illegal payloads and hands
// READ bursts to the read issuer. The source cannot stall, so every word is
// handled in the cycle it arrives.
module cpu_cmd_decoder
   import cmd_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int RD_CNT_WIDTH = 4
) (
   input logic              clk_i,
   input logic              reset,
   cpu_cmd_decoder_if.slave bus
);
   localparam int RC_W = RD_CNT_WIDTH + 1;

   parse_state_t          state_q, state_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [LEN_W-1:0]      left_q, left_n;
   logic                  count_skip_q, count_skip_n;
   logic                  reg_we_q, reg_we_n;
   logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_n;
   logic [DATA_WIDTH-1:0] reg_data_q, reg_data_n;
   logic                  err_q, err_n, err_set;
   logic [15:0]           cnt_q, cnt_n;
   logic                  rd_load, issuer_active;

   logic                    hdr_valid;
   logic [2:0]              hdr_op;
   logic [LEN_W-1:0]        hdr_len;
   logic [RD_CNT_WIDTH-1:0] hdr_rcnt;
   logic [ADDR_WIDTH-1:0]   hdr_addr;
   logic [RC_W-1:0]         rd_load_cnt;

   assign hdr_valid   = bus.cmd_data_i[TOCPU_BIT];
   assign hdr_op      = bus.cmd_data_i[OP_MSB:OP_LSB];
   assign hdr_len     = bus.cmd_data_i[LEN_MSB:LEN_LSB];
   assign hdr_rcnt    = bus.cmd_data_i[RCNT_LSB+RD_CNT_WIDTH-1:RCNT_LSB];
   assign hdr_addr    = bus.cmd_data_i[ADDR_WIDTH-1:0];
   assign rd_load_cnt = {1'b0, hdr_rcnt} + RC_W'(1);

   // Next-state, write strobe, counter and error decisions for the current word
   always_comb begin
      state_n      = state_q;
      addr_n       = addr_q;
      left_n       = left_q;
      count_skip_n = count_skip_q;
      reg_we_n     = 1'b0;
      reg_addr_n   = reg_addr_q;
      reg_data_n   = reg_data_q;
      cnt_n        = cnt_q;
      err_set      = 1'b0;
      rd_load      = 1'b0;
      if (bus.cmd_we_i) begin
         case (state_q)
            ST_IDLE: begin
               if (!hdr_valid) begin
                  err_set = 1'b1;
               end else begin
                  left_n = hdr_len;
                  case (hdr_op)
                     OP_WRITE: begin
                        addr_n = hdr_addr;
                        if (hdr_len == '0) cnt_n = cnt_q + 16'd1;
                        else               state_n = ST_WRITE;
                     end
                     OP_NOP: begin
                        count_skip_n = 1'b1;
                        if (hdr_len == '0) cnt_n = cnt_q + 16'd1;
                        else               state_n = ST_SKIP;
                     end
                     OP_READ: begin
                        // A burst already in flight is never disturbed
                        if (issuer_active) err_set = 1'b1;
                        else               rd_load = 1'b1;
                        count_skip_n = 1'b1;
                        if (hdr_len == '0) begin
                           cnt_n = cnt_q + 16'd1;
                        end else begin
                           err_set = 1'b1;
                           state_n = ST_SKIP;
                        end
                     end
                     default: begin
                        // Illegal opcode: payload is dropped and never counted
                        err_set      = 1'b1;
                        count_skip_n = 1'b0;
                        if (hdr_len != '0) state_n = ST_SKIP;
                     end
                  endcase
               end
            end
            ST_WRITE: begin
               reg_we_n   = 1'b1;
               reg_addr_n = addr_q;
               reg_data_n = bus.cmd_data_i;
               addr_n     = addr_q + ADDR_WIDTH'(1);
               left_n     = left_q - LEN_W'(1);
               if (left_q == LEN_W'(1)) begin
                  state_n = ST_IDLE;
                  cnt_n   = cnt_q + 16'd1;
               end
            end
            ST_SKIP: begin
               left_n = left_q - LEN_W'(1);
               if (left_q == LEN_W'(1)) begin
                  state_n = ST_IDLE;
                  if (count_skip_q) cnt_n = cnt_q + 16'd1;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
      // A new error outranks a simultaneous clear
      err_n = err_set | (err_q & ~bus.err_clr_i);
   end

   // Parser state and registered outputs
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         left_q       <= '0;
         count_skip_q <= 1'b0;
         reg_we_q     <= 1'b0;
         reg_addr_q   <= '0;
         reg_data_q   <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_n;
         addr_q       <= addr_n;
         left_q       <= left_n;
         count_skip_q <= count_skip_n;
         reg_we_q     <= reg_we_n;
         reg_addr_q   <= reg_addr_n;
         reg_data_q   <= reg_data_n;
         err_q        <= err_n;
         cnt_q        <= cnt_n;
      end
   end

   cmd_rd_issuer #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .RD_CNT_WIDTH(RD_CNT_WIDTH)
   ) u_rd_issuer (
      .clk_i    (clk_i),
      .reset    (reset),
      .load     (rd_load),
      .load_addr(hdr_addr),
      .load_cnt (rd_load_cnt),
      .ready    (bus.rd_ready_i),
      .req      (bus.rd_req_o),
      .addr     (bus.rd_addr_o),
      .active   (issuer_active)
   );

   assign bus.reg_we_o   = reg_we_q;
   assign bus.reg_addr_o = reg_addr_q;
   assign bus.reg_data_o = reg_data_q;
   assign bus.err_o      = err_q;
   assign bus.cmd_cnt_o  = cnt_q;
   assign bus.busy_o     = (state_q != ST_IDLE) | issuer_active;

endmodule

// File: tb/tb_cpu_cmd_decoder.sv
// Bench for cpu_cmd_decoder: directed packets from the plan followed by
// randomized packet streams, all checked against a packet-level model.
module tb_cpu_cmd_decoder;
   logic clk = 1'b0;
   logic rst;

   cpu_cmd_decoder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

   cpu_cmd_decoder #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (8),
      .RD_CNT_WIDTH(4)
   ) dut (
      .clk_i(clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining payload words, pending read addresses,
   // sticky error, command count and the write expected next cycle.
   int          wr_left, skip_left;
   bit          skip_counts;
   logic [7:0]  m_waddr;
   logic [7:0]  rq[$];
   logic        m_err;
   logic [15:0] m_cnt;
   logic        e_we;
   logic [7:0]  e_waddr;
   logic [31:0] e_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      wr_left = 0; skip_left = 0; skip_counts = 0;
      m_waddr = 0; rq.delete(); m_err = 0; m_cnt = 0;
      e_we = 0; e_waddr = 0; e_wdata = 0;
   endtask

   // Effect of one clock edge with the given inputs
   task automatic model_edge(input logic we, input logic [31:0] d, input logic rdy, input logic clr);
      bit hs, load, eset;
      int len;
      logic [7:0] base;
      int rcnt;
      hs = (rq.size() != 0) && rdy;
      load = 0; eset = 0; e_we = 0; base = 0; rcnt = 0;
      if (we) begin
         if (wr_left > 0) begin
            e_we = 1; e_waddr = m_waddr; e_wdata = d;
            m_waddr = m_waddr + 8'd1;
            wr_left--;
            if (wr_left == 0) m_cnt++;
         end else if (skip_left > 0) begin
            skip_left--;
            if (skip_left == 0 && skip_counts) m_cnt++;
         end else if (!d[31]) begin
            eset = 1;
         end else begin
            len = int'(d[27:20]);
            case (d[30:28])
               3'd1: begin
                  m_waddr = d[7:0];
                  if (len == 0) m_cnt++; else wr_left = len;
               end
               3'd0: begin
                  skip_counts = 1;
                  if (len == 0) m_cnt++; else skip_left = len;
               end
               3'd2: begin
                  if (rq.size() == 0) begin
                     load = 1; base = d[7:0]; rcnt = int'(d[19:16]);
                  end else eset = 1;
                  skip_counts = 1;
                  if (len == 0) m_cnt++;
                  else begin eset = 1; skip_left = len; end
               end
               default: begin
                  eset = 1; skip_counts = 0;
                  skip_left = len;
               end
            endcase
         end
      end
      if (hs) void'(rq.pop_front());
      if (load) for (int i = 0; i <= rcnt; i++) rq.push_back(base + 8'(i));
      if (eset) m_err = 1;
      else if (clr) m_err = 0;
   endtask

   task automatic check_outputs();
      chk("reg_we", bus.reg_we_o, e_we);
      if (e_we) begin
         chk("reg_addr", bus.reg_addr_o, e_waddr);
         chk("reg_data", bus.reg_data_o, e_wdata);
      end
      chk("rd_req", bus.rd_req_o, rq.size() != 0);
      if (rq.size() != 0) chk("rd_addr", bus.rd_addr_o, rq[0]);
      chk("busy", bus.busy_o, (wr_left != 0) || (skip_left != 0) || (rq.size() != 0));
      chk("err", bus.err_o, m_err);
      chk("cmd_cnt", bus.cmd_cnt_o, m_cnt);
   endtask

   // Drive one cycle of inputs at the falling edge, check after the next rise
   task automatic step(input logic we, input logic [31:0] d, input logic rdy, input logic clr);
      bus.cmd_we_i   = we;
      bus.cmd_data_i = d;
      bus.rd_ready_i = rdy;
      bus.err_clr_i  = clr;
      model_edge(we, d, rdy, clr);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy, 1'b0);
   endtask

   task automatic send_rand(input logic [31:0] d);
      while ($urandom_range(0, 3) == 0)
         step(1'b0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      step(1'b1, d, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_we_i = 0; bus.cmd_data_i = 0; bus.rd_ready_i = 0; bus.err_clr_i = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      rst = 1'b0;

      // Basic two-word write
      step(1, 32'h9020_0010, 0, 0);
      step(1, 32'h0000_000A, 0, 0);
      step(1, 32'h0000_000B, 0, 0);
      idle(2, 0);

      // Address wrap across the top of the register space
      step(1, 32'h9030_00FE, 0, 0);
      step(1, 32'h0000_0001, 0, 0);
      step(1, 32'h0000_0002, 0, 0);
      step(1, 32'h0000_0003, 0, 0);
      idle(1, 0);

      // Read burst with ready toggling 1,0,1,1,1
      step(1, 32'hA003_0040, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      idle(1, 1);

      // Second read while three are pending is dropped
      step(1, 32'hA003_0080, 0, 0);
      step(0, 0, 1, 0);
      step(1, 32'hA001_0000, 0, 0);
      idle(4, 1);
      step(0, 0, 0, 1);

      // Error set beats a same-cycle clear
      step(1, 32'h0000_0001, 0, 1);
      step(0, 0, 0, 1);

      // Illegal opcode with payload, then a normal write
      step(1, 32'hF020_0000, 0, 0);
      step(1, 32'h9020_0010, 0, 0);
      step(1, 32'h1234_5678, 0, 0);
      step(1, 32'h9010_0033, 0, 0);
      step(1, 32'h0000_0055, 0, 0);
      idle(1, 0);

      // Asynchronous reset in the middle of a write packet
      step(1, 32'h9040_0020, 0, 0);
      step(1, 32'h0000_1111, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_reg_we", bus.reg_we_o, 0);
      chk("rst_reg_addr", bus.reg_addr_o, 0);
      chk("rst_reg_data", bus.reg_data_o, 0);
      chk("rst_rd_req", bus.rd_req_o, 0);
      chk("rst_rd_addr", bus.rd_addr_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_cmd_cnt", bus.cmd_cnt_o, 0);
      bus.cmd_we_i = 0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(1, 32'h9010_0005, 0, 0);
      step(1, 32'h0000_CAFE, 0, 0);
      idle(1, 0);

      // Randomized packet stream
      for (int p = 0; p < 400; p++) begin
         int kind, len;
         logic [2:0] op;
         logic [31:0] hdr;
         kind = $urandom_range(0, 9);
         len  = $urandom_range(0, 4);
         case (kind)
            0, 1, 2, 3: op = 3'd1;
            4:          op = 3'd0;
            5, 6: begin op = 3'd2; if ($urandom_range(0, 3) != 0) len = 0; end
            default:    op = 3'($urandom_range(3, 7));
         endcase
         hdr = {1'b1, op, 8'(len), 4'($urandom_range(0, 15)), 8'h00, 8'($urandom)};
         if (kind == 9) begin
            hdr = $urandom & 32'h7FFF_FFFF;
            len = 0;
         end
         send_rand(hdr);
         for (int w = 0; w < len; w++) send_rand($urandom);
      end
      idle(40, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_cmd_decoder.md
Name: cpu_cmd_decoder

Overview:
- Sits directly downstream of the FTDI-to-FIFO/CPU selector and consumes its CPU-side word stream (cpu_data/cpu_we).
- Parses command packets: one header word plus LEN payload words.
- Issues register-bank writes, and queues register read requests to the readback path.
- The source cannot be stalled, so every accepted word is processed or discarded in the cycle it arrives.

Parameters:
- DATA_WIDTH, 32, command and data word width.
- ADDR_WIDTH, 8, register address width; addresses wrap modulo 2^ADDR_WIDTH.
- RD_CNT_WIDTH, 4, width of the header read-count field (max burst 2^RD_CNT_WIDTH).

Ports:
- clk_i  in  1  single clock, the same FTDI clock the selector uses; sampled on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_data_i  in  DATA_WIDTH  word from the selector's CPU output.
- cmd_we_i  in  1  word valid; no backpressure exists.
- reg_we_o  out  1  register write strobe, one cycle per word.
- reg_addr_o  out  ADDR_WIDTH  write address.
- reg_data_o  out  DATA_WIDTH  write data.
- rd_req_o  out  1  read request valid.
- rd_addr_o  out  ADDR_WIDTH  read address.
- rd_ready_i  in  1  readback path accepts the request when rd_req_o and rd_ready_i are both 1.
- busy_o  out  1  the parser is not in IDLE, or reads are pending.
- err_o  out  1  sticky error flag.
- err_clr_i  in  1  clears err_o.
- cmd_cnt_o  out  16  count of completed commands; wraps at 0xFFFF to 0.

Behaviour:
- Header format:
  - [31] must be 1.
  - [30:28] opcode: 0 = NOP, 1 = WRITE, 2 = READ, others illegal.
  - [27:20] LEN, the number of payload words that follow.
  - [19:16] RCNT; a READ issues RCNT+1 reads.
  - [ADDR_WIDTH-1:0] ADDR.
- Reset: every output is 0, the parser is in IDLE, and the read issuer is idle. Reset asserted mid-packet abandons the packet; the first word after release is treated as a header.
- Parser states are IDLE, WRITE and SKIP. A word is consumed only when cmd_we_i=1.
- IDLE with header bit31=0: set err_o, stay in IDLE.
- IDLE with WRITE:
  - Latch ADDR and LEN.
  - If LEN=0, the command completes immediately (cmd_cnt_o+1).
  - Otherwise go to WRITE.
- WRITE state, for each payload word:
  - reg_we_o=1, reg_data_o=word, reg_addr_o=current address, registered; this is 1 cycle of latency from word sample to strobe.
  - The address increments by 1 with wrap.
  - After the LEN-th word: return to IDLE and increment cmd_cnt_o.
- NOP: if LEN>0 go to SKIP; otherwise complete immediately.
- SKIP state: discard LEN words, then return to IDLE and increment cmd_cnt_o.
- READ:
  - If the read issuer is idle, load the issuer with address ADDR and count RCNT+1.
  - If the issuer is busy, drop the request and set err_o.
  - If LEN>0, set err_o and go to SKIP.
  - The command is counted when the parser completes it, not when the reads finish.
- Illegal opcode: set err_o, go to SKIP if LEN>0; the command is not counted.
- Read issuer:
  - rd_req_o is held high with a stable rd_addr_o until the handshake.
  - On each handshake the address increments (wrapping) and the remaining count decrements.
  - rd_req_o deasserts in the cycle after the last handshake.
  - The issuer runs concurrently with write parsing.
- err_o: a set event and err_clr_i in the same cycle leaves err_o=1 (set wins).
- busy_o is combinational: (state != IDLE) OR the issuer is active.

Decomposition:
- Shared package cmd_pkg holds:
  - opcode constants OP_NOP, OP_WRITE, OP_READ;
  - header field bit positions (LEN_MSB/LSB = 27/20, RCNT 19:16, TOCPU bit 31);
  - parser state encodings.
- The selector should later reuse the LEN positions from cmd_pkg.
- One sub-module, cmd_rd_issuer: a load/count/handshake engine for the read burst.

Test Plan:
- WRITE header 0x9020_0010 followed by payloads 0xA, 0xB, each with cmd_we=1:
  - reg_we pulses twice: addr 0x10 data 0xA, then addr 0x11 data 0xB;
  - cmd_cnt_o=1, err_o=0.
- WRITE header 0x9030_00FE with 3 payloads (ADDR_WIDTH=8): the addresses written are 0xFE, 0xFF, 0x00 (wrap).
- READ header 0xA003_0040 with rd_ready_i toggling 1,0,1,1,1:
  - rd_addr_o sequence is 0x40, 0x41, 0x42, 0x43, with each address held while ready=0;
  - rd_req_o drops after the 4th handshake.
- Second READ arrives while 3 reads are pending: the request is dropped, err_o=1, and the pending burst completes unchanged; err_clr_i pulse sets err_o to 0.
- Header 0xF020_0000 (illegal opcode 7, LEN=2) followed by 2 words, then a WRITE: no reg_we for the skipped words, err_o=1, and the following WRITE executes normally.
- Reset asserted after 1 of 4 WRITE payload words:
  - all outputs are 0 immediately (asynchronously);
  - after release, the next word 0x9010_0005 is parsed as a header.
